rtype_encoder: RTL and testbench

//   Inverse of the ALU control decode: accepts a 4-bit ALU control code plus

---
 rtl/rtype_encoder.sv | 113 +++++++++++
 tb/tb_rtype_encoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rtype_encoder.sv
// Builds MIPS R-type instruction words from an ALU control code plus register fields.
// A small FIFO sits between the request side and the consumer.
module rtype_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alucontrol,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [7:0]       err_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [32:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [7:0]       err_count_q, err_count_d;

  logic [5:0]  funct;
  logic        enc_err;
  logic [4:0]  rs_fld;
  logic [4:0]  shamt_fld;
  logic [32:0] entry_d;
  logic        push;
  logic        pop;
  logic        full;

  always_comb begin
    funct     = 6'b000000;
    enc_err   = 1'b0;
    rs_fld    = in_rs;
    shamt_fld = 5'd0;
    case (in_alucontrol)
      4'b0010: funct = 6'b100000;
      4'b1010: funct = 6'b100010;
      4'b0000: funct = 6'b100100;
      4'b0001: funct = 6'b100101;
      4'b1011: funct = 6'b101010;
      4'b0100: begin
        funct     = 6'b000000;
        rs_fld    = 5'd0;
        shamt_fld = in_shamt;
      end
      default: enc_err = 1'b1;
    endcase
    // Unsupported codes still occupy a slot, carrying a nop and the error flag.
    if (enc_err) entry_d = {1'b1, 32'h0};
    else         entry_d = {1'b0, 6'b000000, rs_fld, in_rt, in_rd, shamt_fld, funct};
  end

  assign full      = (occ_q == OCC_W'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (occ_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
  assign out_err   = out_valid ? mem_q[rd_ptr_q][32]   : 1'b0;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      enc_count_d = enc_count_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (push && enc_err && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      enc_count_q <= '0;
      err_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
      if (push) mem_q[wr_ptr_q] <= entry_d;
    end
  end

endmodule

// File: tb/tb_rtype_encoder.sv
// Directed checks of rtype_encoder: encodings, error counting, FIFO back-pressure,
// streaming throughput against a scoreboard, and mid-stream reset.
module tb_rtype_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alucontrol;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_enc  = 0;
  logic [32:0] sb_q[$];

  rtype_encoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alucontrol(in_alucontrol), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encoder used only for the random stream; directed cases use literal words.
  function automatic logic [32:0] ref_word(input logic [3:0] c, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sh);
    logic [31:0] base;
    base = {6'd0, rs, rt, rd, 5'd0, 6'd0};
    case (c)
      4'b0010: return {1'b0, base | 32'h20};
      4'b1010: return {1'b0, base | 32'h22};
      4'b0000: return {1'b0, base | 32'h24};
      4'b0001: return {1'b0, base | 32'h25};
      4'b1011: return {1'b0, base | 32'h2A};
      4'b0100: return {1'b0, 6'd0, 5'd0, rt, rd, sh, 6'd0};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic drive(input logic [3:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh);
    in_valid      = 1'b1;
    in_alucontrol = c;
    in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
  endtask

  // Single request into an empty FIFO with the consumer ready.
  task automatic do_one(input string tag, input logic [3:0] c, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [31:0] exp_word, input logic exp_err);
    @(negedge clk);
    out_ready = 1'b1;
    drive(c, rs, rt, rd, sh);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_instr"}, out_instr, exp_word);
    check_eq({tag, "_err"},   32'(out_err), 32'(exp_err));
    @(posedge clk);
    exp_enc++;
    @(negedge clk);
    check_eq({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  task automatic stream_bad(input int n);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive(4'b1111, 5'd3, 5'd3, 5'd3, 5'd3);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    exp_enc += n;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alucontrol = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_instr", out_instr, 32'h0);
    check_eq("rst_out_err",   32'(out_err), 32'd0);
    check_eq("rst_enc_count", 32'(enc_count), 32'd0);
    check_eq("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    do_one("add", 4'b0010, 5'd1, 5'd2, 5'd3, 5'd7, 32'h00221820, 1'b0);
    check_eq("add_enc_count", 32'(enc_count), 32'd1);
    do_one("sll", 4'b0100, 5'd9, 5'd5, 5'd4, 5'd2, 32'h00052080, 1'b0);
    do_one("sub", 4'b1010, 5'd1, 5'd2, 5'd3, 5'd0, 32'h00221822, 1'b0);
    do_one("and", 4'b0000, 5'd1, 5'd2, 5'd3, 5'd9, 32'h00221824, 1'b0);
    do_one("or",  4'b0001, 5'd1, 5'd2, 5'd3, 5'd0, 32'h00221825, 1'b0);
    do_one("slt", 4'b1011, 5'd9, 5'd10, 5'd8, 5'd0, 32'h012A402A, 1'b0);
    check_eq("pre_bad_err_count", 32'(err_count), 32'd0);
    do_one("bad", 4'b1111, 5'd9, 5'd10, 5'd8, 5'd1, 32'h0, 1'b1);
    check_eq("bad_err_count", 32'(err_count), 32'd1);

    stream_bad(253);
    @(negedge clk);
    check_eq("err_count_254", 32'(err_count), 32'd254);
    stream_bad(3);
    @(negedge clk);
    check_eq("err_count_sat", 32'(err_count), 32'd255);
    check_eq("enc_after_bad", 32'(enc_count), 32'(exp_enc));

    // Back-pressure: fill, hold a third request, then release.
    out_ready = 1'b0;
    drive(4'b0010, 5'd1, 5'd2, 5'd3, 5'd0);
    @(posedge clk); @(negedge clk);
    check_eq("bp_ready_after1", 32'(in_ready), 32'd1);
    drive(4'b1010, 5'd4, 5'd5, 5'd6, 5'd0);
    @(posedge clk); @(negedge clk);
    check_eq("bp_ready_after2", 32'(in_ready), 32'd0);
    drive(4'b0001, 5'd7, 5'd8, 5'd9, 5'd0);
    @(posedge clk); @(negedge clk);
    check_eq("bp_hold_instr", out_instr, 32'h00221820);
    check_eq("bp_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("bp_pop_no_push", 32'(in_ready), 32'd1);
    check_eq("bp_second", out_instr, 32'h00853022);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check_eq("bp_third", out_instr, 32'h00E84825);
    @(posedge clk); @(negedge clk);
    check_eq("bp_empty", 32'(out_valid), 32'd0);
    exp_enc += 3;
    check_eq("bp_enc_count", 32'(enc_count), 32'(exp_enc));

    // Streaming: one push and one pop per cycle against the scoreboard.
    begin
      logic [3:0] codes [8];
      logic [3:0] c;
      logic [4:0] rs, rt, rd, sh;
      logic [32:0] e;
      codes = '{4'b0010, 4'b1010, 4'b0000, 4'b0001, 4'b1011, 4'b0100, 4'b1111, 4'b0111};
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
        if (i > 0) begin
          e = sb_q.pop_front();
          check_eq("st_valid", 32'(out_valid), 32'd1);
          check_eq("st_instr", out_instr, e[31:0]);
          check_eq("st_err",   32'(out_err), 32'(e[32]));
        end
        check_eq("st_ready", 32'(in_ready), 32'd1);
        c  = codes[$urandom_range(7, 0)];
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
        drive(c, rs, rt, rd, sh);
        sb_q.push_back(ref_word(c, rs, rt, rd, sh));
        @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0;
      e = sb_q.pop_front();
      check_eq("st_last_instr", out_instr, e[31:0]);
      @(posedge clk); @(negedge clk);
      exp_enc += 100;
      check_eq("st_enc_count", 32'(enc_count), 32'(exp_enc));
      check_eq("st_err_count", 32'(err_count), 32'd255);
    end

    // Mid-stream reset with two entries queued.
    out_ready = 1'b0;
    drive(4'b0010, 5'd1, 5'd1, 5'd1, 5'd0);
    @(posedge clk); @(negedge clk);
    drive(4'b0010, 5'd2, 5'd2, 5'd2, 5'd0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check_eq("mr_queued", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_out_valid", 32'(out_valid), 32'd0);
    check_eq("mr_enc_count", 32'(enc_count), 32'd0);
    check_eq("mr_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(4'b1011, 5'd9, 5'd10, 5'd8, 5'd0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check_eq("mr_new_valid", 32'(out_valid), 32'd1);
    check_eq("mr_new_instr", out_instr, 32'h012A402A);
    @(posedge clk); @(negedge clk);
    check_eq("mr_only_one", 32'(out_valid), 32'd0);
    check_eq("mr_enc_after", 32'(enc_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
